// File: rtl/twiddle_seq.sv
// twiddle_seq: streams the radix-2 DIT twiddle factors W_N^k of one FFT stage.
// The values come from a quarter-wave sine ROM that is built at elaboration.
// The output stream uses a valid/ready handshake with a two-stage pipeline.
module twiddle_seq #(
   parameter int LOG2N = 6,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [$clog2(LOG2N)-1:0]   stage,
   input  logic                       inverse,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic signed [WIDTH-1:0]    tw_re,
   output logic signed [WIDTH-1:0]    tw_im,
   output logic [LOG2N-2:0]           tw_idx,
   output logic                       last,
   output logic                       busy
);

   localparam int     N      = 1 << LOG2N;
   localparam int     Q      = N / 4;
   localparam int     CW     = LOG2N - 1;              // counter, exponent and ROM address width
   localparam int     SW     = $clog2(LOG2N);
   localparam longint A      = longint'(1) << (WIDTH - 1);
   localparam longint PI_F   = 64'sd3373259426;        // pi scaled by 2^30
   localparam logic [CW-1:0] LAST_C = '1;             // N/2-1

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   // Folded ROM access: magnitude address plus a sign flag.
   typedef struct packed {
      logic          neg;
      logic [CW-1:0] addr;
   } fold_t;

   // round(A*sin(2*pi*q/N)) clipped to A-1, using 2^30 fixed-point Taylor series.
   function automatic int sin_q(input int q);
      longint x, x2, term, acc, r;
      x    = (2 * PI_F * longint'(q)) / longint'(N);
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         acc  = acc + term;
      end
      r = (acc * A + (longint'(1) <<< 29)) >>> 30;
      if (r > A - 1) r = A - 1;
      return int'(r);
   endfunction

   // Map a full-circle exponent onto the quarter-wave table.
   function automatic fold_t fold(input logic [LOG2N-1:0] kk);
      fold_t         f;
      logic [CW-1:0] off;
      off    = {1'b0, kk[LOG2N-3:0]};
      f.neg  = kk[LOG2N-1];
      f.addr = kk[LOG2N-2] ? (CW'(Q) - off) : off;
      return f;
   endfunction

   logic signed [WIDTH-1:0] rom_w [0:Q];

   for (genvar g = 0; g <= Q; g++) begin : g_rom
      localparam int VAL = sin_q(g);
      assign rom_w[g] = WIDTH'(VAL);
   end

   state_e                  state_q, state_d;
   logic [CW-1:0]           c_q, c_d;
   logic [SW-1:0]           s_q, s_d;
   logic                    inv_q, inv_d;
   logic                    en_w, issue_w, accept_w;
   logic [SW-1:0]           stage_sat_w, sh_w;
   logic [CW-1:0]           mask_w, k_d;
   fold_t                   sin_d, cos_d;
   logic                    p1_valid_q, p1_last_q;
   logic [CW-1:0]           p1_k_q;
   fold_t                   p1_sin_q, p1_cos_q;
   logic signed [WIDTH-1:0] re_d, im_d, re_q, im_q;
   logic [CW-1:0]           idx_q;
   logic                    out_valid_q, last_q;

   // The whole pipeline moves together whenever the output register can accept.
   assign en_w        = !out_valid_q || out_ready;
   assign stage_sat_w = (int'(stage) > LOG2N - 1) ? SW'(LOG2N - 1) : stage;
   assign sh_w        = SW'(LOG2N - 1) - s_q;
   assign mask_w      = CW'((LOG2N'(1) << s_q) - LOG2N'(1));
   assign k_d         = (c_q & mask_w) << sh_w;
   assign sin_d       = fold({1'b0, k_d});
   assign cos_d       = fold({1'b0, k_d} + LOG2N'(Q));

   // Forward mode outputs -sin, inverse mode +sin.
   assign re_d = p1_cos_q.neg ? -rom_w[p1_cos_q.addr] : rom_w[p1_cos_q.addr];
   assign im_d = (p1_sin_q.neg ^ !inv_q) ? -rom_w[p1_sin_q.addr] : rom_w[p1_sin_q.addr];

   // State register.
   // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: start only counts in IDLE; DRAIN ends on the last handshake.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (issue_w && c_q == LAST_C) state_d = DRAIN;
         DRAIN:   if (out_valid_q && out_ready && last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy flag, start acceptance and per-cycle index issue.
   always_comb begin
      busy     = (state_q != IDLE);
      accept_w = (state_q == IDLE) && start;
      issue_w  = (state_q == RUN) && en_w;
   end

   // Counter and stream parameters: latched on acceptance, counter steps per issue.
   always_comb begin
      c_d   = c_q;
      s_d   = s_q;
      inv_d = inv_q;
      if (accept_w) begin
         c_d   = '0;
         s_d   = stage_sat_w;
         inv_d = inverse;
      end else if (issue_w) begin
         c_d = c_q + CW'(1);
      end
   end

   // Counter and stream parameter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q   <= '0;
         s_q   <= '0;
         inv_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         s_q   <= s_d;
         inv_q <= inv_d;
      end
   end

   // P1: exponent, folded ROM addresses and sign flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_valid_q <= 1'b0;
         p1_last_q  <= 1'b0;
         p1_k_q     <= '0;
         p1_sin_q   <= '0;
         p1_cos_q   <= '0;
      end else if (en_w) begin
         p1_valid_q <= issue_w;
         if (issue_w) begin
            p1_last_q <= (c_q == LAST_C);
            p1_k_q    <= k_d;
            p1_sin_q  <= sin_d;
            p1_cos_q  <= cos_d;
         end
      end
   end

   // P2: output register; data only changes when a new beat enters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         re_q        <= '0;
         im_q        <= '0;
         idx_q       <= '0;
      end else if (en_w) begin
         out_valid_q <= p1_valid_q;
         last_q      <= p1_valid_q && p1_last_q;
         if (p1_valid_q) begin
            re_q  <= re_d;
            im_q  <= im_d;
            idx_q <= p1_k_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign last      = last_q;
   assign tw_re     = re_q;
   assign tw_im     = im_q;
   assign tw_idx    = idx_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// tb_twiddle_seq: scoreboard bench for twiddle_seq at default size and at
// LOG2N=8/WIDTH=12. Expected beats come from a trig model of the stage rules.
module tb_twiddle_seq;

   localparam real PI = 3.14159265358979323846;

   typedef struct {
      int re;
      int im;
      int idx;
      bit last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Default-size instance.
   logic              start0 = 1'b0, inverse0 = 1'b0, out_ready0 = 1'b1;
   logic [2:0]        stage0 = '0;
   logic              out_valid0, last0, busy0;
   logic signed [8:0] tw_re0, tw_im0;
   logic [4:0]        tw_idx0;

   // LOG2N=8, WIDTH=12 instance.
   logic               start1 = 1'b0, inverse1 = 1'b0, out_ready1 = 1'b1;
   logic [2:0]         stage1 = '0;
   logic               out_valid1, last1, busy1;
   logic signed [11:0] tw_re1, tw_im1;
   logic [6:0]         tw_idx1;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    beats0   = 0;
   bit    ready_rand0 = 1'b0;
   bit    inv_cur0 = 1'b0;
   beat_t q0[$];
   beat_t q1[$];

   twiddle_seq u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .stage(stage0), .inverse(inverse0),
      .out_ready(out_ready0), .out_valid(out_valid0), .tw_re(tw_re0), .tw_im(tw_im0),
      .tw_idx(tw_idx0), .last(last0), .busy(busy0)
   );

   twiddle_seq #(.LOG2N(8), .WIDTH(12)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stage(stage1), .inverse(inverse1),
      .out_ready(out_ready1), .out_valid(out_valid1), .tw_re(tw_re1), .tw_im(tw_im1),
      .tw_idx(tw_idx1), .last(last1), .busy(busy1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Symmetric quantiser: round(A*|v|) clipped to A-1, sign restored.
   function automatic int quant(input real v, input int a);
      int m;
      m = $rtoi(((v < 0.0) ? -v : v) * a + 0.5);
      if (m > a - 1) m = a - 1;
      return (v < 0.0) ? -m : m;
   endfunction

   function automatic beat_t model(input int k, input int log2n, input int width,
                                   input bit inv, input bit lst);
      beat_t b;
      real   ang;
      int    a;
      ang    = 2.0 * PI * k / (1 << log2n);
      a      = 1 << (width - 1);
      b.re   = quant($cos(ang), a);
      b.im   = inv ? quant($sin(ang), a) : -quant($sin(ang), a);
      b.idx  = k;
      b.last = lst;
      return b;
   endfunction

   // Expected stream of one stage: butterfly c uses k = (c mod 2^s) * N/2^(s+1).
   task automatic push_stream(input bit which, input int st, input bit inv);
      int    log2n, width, s, half;
      beat_t b;
      log2n = which ? 8 : 6;
      width = which ? 12 : 9;
      half  = 1 << (log2n - 1);
      s     = (st > log2n - 1) ? log2n - 1 : st;
      for (int c = 0; c < half; c++) begin
         b = model((c % (1 << s)) * (half >> s), log2n, width, inv, c == half - 1);
         if (which) q1.push_back(b);
         else       q0.push_back(b);
      end
   endtask

   task automatic pulse_start0(input int st, input bit inv, input bit accept);
      @(posedge clk); #1;
      start0 = 1'b1; stage0 = 3'(st); inverse0 = inv;
      if (accept) begin
         push_stream(1'b0, st, inv);
         inv_cur0 = inv;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
   endtask

   task automatic pulse_start1(input int st, input bit inv);
      @(posedge clk); #1;
      start1 = 1'b1; stage1 = 3'(st); inverse1 = inv;
      push_stream(1'b1, st, inv);
      @(posedge clk); #1;
      start1 = 1'b0;
   endtask

   task automatic wait_idle(input bit which, input string name);
      int cyc;
      cyc = 0;
      while (cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (which ? (!busy1 && q1.size() == 0) : (!busy0 && q0.size() == 0)) break;
      end
      check({name, "_finished"}, int'(cyc < 3000), 1);
      check({name, "_sb_empty"}, which ? q1.size() : q0.size(), 0);
   endtask

   // Spec spot values for the default instance.
   task automatic spot0();
      int er, em;
      case (int'(tw_idx0))
         0:       begin er = 255;  em = 0;   end
         8:       begin er = 181;  em = 181; end
         16:      begin er = 0;    em = 255; end
         24:      begin er = -181; em = 181; end
         default: return;
      endcase
      check("spot_re0", int'(tw_re0), er);
      check("spot_im0", int'(tw_im0), inv_cur0 ? em : -em);
   endtask

   // Ready driver for the default instance: always ready, or a coin flip per cycle.
   initial forever begin
      @(posedge clk); #1;
      out_ready0 = ready_rand0 ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor 0: pops on every handshake and checks that stalled outputs hold.
   initial begin : mon0
      bit          stalled;
      logic [23:0] held;
      beat_t       e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) check("stall_hold0", int'({tw_re0, tw_im0, tw_idx0, last0}), int'(held));
         stalled = out_valid0 && !out_ready0;
         held    = {tw_re0, tw_im0, tw_idx0, last0};
         if (out_valid0 && out_ready0) begin
            beats0++;
            if (q0.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_beat0: got idx %0d, expected no beat", tw_idx0);
            end else begin
               e = q0.pop_front();
               check("re0", int'(tw_re0), e.re);
               check("im0", int'(tw_im0), e.im);
               check("idx0", int'(tw_idx0), e.idx);
               check("last0", int'(last0), int'(e.last));
               spot0();
            end
         end
      end
   end

   // Monitor 1: large instance, always ready.
   initial begin : mon1
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_beat1: got idx %0d, expected no beat", tw_idx1);
            end else begin
               e = q1.pop_front();
               check("re1", int'(tw_re1), e.re);
               check("im1", int'(tw_im1), e.im);
               check("idx1", int'(tw_idx1), e.idx);
               check("last1", int'(last1), int'(e.last));
               if (tw_idx1 == 7'd0)  check("peak_re1", int'(tw_re1), 2047);
               if (tw_idx1 == 7'd32) check("k32_re1", int'(tw_re1), 1448);
               if (tw_idx1 == 7'd32) check("k32_im1", int'(tw_im1), inverse1 ? 1448 : -1448);
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int b, cyc;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", int'(out_valid0), 0);
      check("rst_busy", int'(busy0), 0);
      check("rst_last", int'(last0), 0);
      check("rst_re", int'(tw_re0), 0);
      rst_n = 1'b1;

      // Forward stage 5 with timing of first beat, last beat and busy.
      pulse_start0(5, 1'b0, 1'b1);
      check("busy_rise", int'(busy0), 1);
      @(posedge clk); #1;
      check("lat1_valid", int'(out_valid0), 0);
      @(posedge clk); #1;
      check("lat2_valid", int'(out_valid0), 1);
      check("lat2_idx", int'(tw_idx0), 0);
      b = 2;
      while (b < 40 && !(out_valid0 && last0)) begin
         @(posedge clk); #1;
         b++;
      end
      check("last_cycle", b, 33);
      @(posedge clk); #1;
      check("busy_fall", int'(busy0), 0);
      check("valid_fall", int'(out_valid0), 0);
      wait_idle(1'b0, "fwd5");

      // Inverse stage 2 and forward stage 0.
      pulse_start0(2, 1'b1, 1'b1);
      wait_idle(1'b0, "inv2");
      pulse_start0(0, 1'b0, 1'b0 == 1'b0);
      wait_idle(1'b0, "fwd0");

      // Random backpressure on stage 4, both directions.
      ready_rand0 = 1'b1;
      pulse_start0(4, 1'b0, 1'b1);
      wait_idle(1'b0, "rnd4f");
      pulse_start0(4, 1'b1, 1'b1);
      wait_idle(1'b0, "rnd4i");
      ready_rand0 = 1'b0;

      // Stage 7 saturates; a start while busy is ignored.
      pulse_start0(7, 1'b0, 1'b1);
      repeat (8) @(posedge clk);
      pulse_start0(1, 1'b1, 1'b0);
      wait_idle(1'b0, "sat7");
      repeat (3) @(posedge clk);
      #1;
      check("no_restart_valid", int'(out_valid0), 0);
      check("no_restart_busy", int'(busy0), 0);

      // Asynchronous reset at beat 10 of a stage 3 run.
      b = beats0;
      pulse_start0(3, 1'b0, 1'b1);
      cyc = 0;
      while (cyc < 200 && beats0 < b + 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("reached_beat10", beats0 - b, 10);
      #1;
      rst_n = 1'b0;
      q0.delete();
      #1;
      check("arst_valid", int'(out_valid0), 0);
      check("arst_last", int'(last0), 0);
      check("arst_busy", int'(busy0), 0);
      check("arst_re", int'(tw_re0), 0);
      check("arst_im", int'(tw_im0), 0);
      check("arst_idx", int'(tw_idx0), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no_resume_valid", int'(out_valid0), 0);
      check("no_resume_busy", int'(busy0), 0);
      pulse_start0(3, 1'b0, 1'b1);
      wait_idle(1'b0, "post_rst3");

      // Large instance: every exponent in both directions.
      pulse_start1(7, 1'b0);
      wait_idle(1'b1, "big_fwd");
      pulse_start1(7, 1'b1);
      wait_idle(1'b1, "big_inv");
      pulse_start1(2, 1'b0);
      wait_idle(1'b1, "big_s2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
